md_unit: RTL and testbench
==========================

# md_unit

Multi-cycle multiply/divide unit for the EX stage, sitting downstream of the ID/EX pipeline register. It takes the operand pair and the decoded multiply/divide operation issued from ID/EX and runs the operation over a fixed number of cycles. Results are committed to internal HI/LO registers. It returns a busy/stall indication so the hazard logic can hold later multiply/divide and HI/LO-read instructions in ID.

## Interface

Parameters:
- MULT_CYCLES, 5, cycles `busy` stays high for mult/multu (≥1)
- DIV_CYCLES, 10, cycles `busy` stays high for div/divu (≥1)

Ports:
- clk  input  1  system clock, rising-edge
- reset  input  1  asynchronous, active-high; clears all state
- start  input  1  issue strobe, one cycle per instruction, valid in the cycle the instruction is in EX
- op  input  3  0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo, 6/7 no-op
- A  input  32  operand rs (forwarded value)
- B  input  32  operand rt (forwarded value)
- busy  output  1  registered; high while an operation is in flight
- stall  output  1  combinational: `busy | (start & op<4)`, consumed by the hazard unit
- HI  output  32  registered HI register
- LO  output  32  registered LO register

## Operation

- State: idle/run, a countdown counter wide enough for max(MULT_CYCLES, DIV_CYCLES), latched result pair (64 bits), HI, LO.
- Reset (async): busy=0, counter=0, HI=0, LO=0, latched result=0; any in-flight operation is discarded.
- Idle, `start` with op 0–3:
  - Latch the result computed from A/B at that edge.
  - Load the counter with MULT_CYCLES (op 0/1) or DIV_CYCLES (op 2/3).
  - Set busy=1.
- Idle, `start` with op 4: HI←A at that edge; busy stays 0. Op 5: LO←A likewise. Op 6/7: no effect.
- Run: decrement the counter each edge. On the edge where the counter goes 1→0, commit the latched result to HI/LO and set busy=0.
- `start` while busy=1 is ignored entirely, including mthi/mtlo. The hazard unit guarantees this never occurs; the verifier checks it is ignored.
- Arithmetic:
  - mult: signed 32×32→64; HI=[63:32], LO=[31:0].
  - multu: unsigned, same split.
  - div: signed; LO=quotient truncated toward zero, HI=remainder with the sign of the dividend.
  - divu: unsigned quotient/remainder.
- Boundary cases:
  - Divide by zero (B=0): runs the full DIV_CYCLES, then HI/LO keep their previous values.
  - Signed div 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
- HI/LO never show partial or intermediate values; they change only at commit or on mthi/mtlo.

## Timing

- `start` sampled at edge T, op mult:
  - busy is high after T, through and including the cycle before edge T+MULT_CYCLES.
  - At edge T+MULT_CYCLES, HI/LO update and busy falls together.
  - Divide is the same with DIV_CYCLES.
- A new `start` is accepted in the first cycle with busy=0, giving back-to-back throughput of one op per N+1 cycles.
- `stall` is high in the issue cycle itself (combinational on `start`) and for all N busy cycles. mfhi/mflo in ID therefore read committed values only.
- mthi/mtlo: 1-cycle latency; the new value is visible after the sampling edge, and `stall` is not raised.
- Reset asserted mid-operation: busy drops immediately (asynchronously), HI/LO=0, and no commit occurs after reset releases.
- First edge after reset deasserts: `start` is sampled normally.

## Test plan

- Reset, then mult A=0xFFFFFFFE (−2), B=3 → busy high exactly 5 cycles; after edge T+5, HI=0xFFFFFFFF, LO=0xFFFFFFFA; stall high in the issue cycle.
- multu A=0xFFFFFFFF, B=0xFFFFFFFF → HI=0xFFFFFFFE, LO=0x00000001 after 5 cycles.
- div A=0xFFFFFFF9 (−7), B=2 → busy 10 cycles; LO=0xFFFFFFFD, HI=0xFFFFFFFF. Then divu A=7, B=0 → HI/LO unchanged after 10 cycles.
- mthi A=0x12345678, then next cycle mtlo A=0x9ABCDEF0 → HI/LO updated one edge each, busy/stall never high. Then mult during busy with a second mult start → second start ignored, result from the first only.
- Start div 100/7, assert reset at cycle 4 of busy → busy=0, HI=LO=0 immediately; after release HI/LO stay 0, no late commit.
- Signed div 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0 after 10 cycles.

Source files
------------

// File: rtl/md_unit.sv
// md_unit: multi-cycle multiply/divide unit with HI/LO registers for the EX stage.
// Ports: clk, reset (async, active-high), start, op[2:0], A, B -> busy, stall, HI, LO.
`timescale 1ns/1ps
module md_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic        stall,
    output logic [31:0] HI,
    output logic [31:0] LO
);
    localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);
    localparam logic [CW-1:0] MC = CW'(MULT_CYCLES);
    localparam logic [CW-1:0] DC = CW'(DIV_CYCLES);

    typedef enum logic {IDLE, RUN} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [63:0]   res_q, res_d;
    logic [31:0]   hi_d, lo_d;

    logic [63:0] prod_s, prod_u, result;
    logic        neg_a, neg_b;
    logic [31:0] ua, ub, divisor, uq, ur, dq, dr;

    assign prod_s = {{32{A[31]}}, A} * {{32{B[31]}}, B};
    assign prod_u = {32'd0, A} * {32'd0, B};

    // Signed divide via magnitudes; op[0] selects unsigned, so both
    // sign flags drop out and the same divider serves divu.
    assign neg_a   = ~op[0] & A[31];
    assign neg_b   = ~op[0] & B[31];
    assign ua      = neg_a ? -A : A;
    assign ub      = neg_b ? -B : B;
    assign divisor = (ub == 32'd0) ? 32'd1 : ub;
    assign uq      = ua / divisor;
    assign ur      = ua % divisor;
    assign dq      = (neg_a ^ neg_b) ? -uq : uq;
    assign dr      = neg_a ? -ur : ur;

    // HI/LO cannot change while busy, so latching their current value
    // on divide-by-zero makes the later commit a no-op.
    always_comb begin
        result = op[0] ? prod_u : prod_s;
        if (op[1])
            result = (B == 32'd0) ? {HI, LO} : {dr, dq};
    end

    assign busy  = (state_q == RUN);
    assign stall = busy | (start & ~op[2]);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        hi_d    = HI;
        lo_d    = LO;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    if (!op[2]) begin
                        res_d   = result;
                        cnt_d   = op[1] ? DC : MC;
                        state_d = RUN;
                    end else if (op == 3'd4) begin
                        hi_d = A;
                    end else if (op == 3'd5) begin
                        lo_d = A;
                    end
                end
            end
            RUN: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CW'(1)) begin
                    hi_d    = res_q[63:32];
                    lo_d    = res_q[31:0];
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            res_q   <= '0;
            HI      <= '0;
            LO      <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            HI      <= hi_d;
            LO      <= lo_d;
        end
    end
endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: directed + random checks of md_unit against an arithmetic model.
// Drives and samples on the falling edge; DUT captures on the rising edge.
`timescale 1ns/1ps
module tb_md_unit;
    localparam int MC = 5;
    localparam int DC = 10;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  op = 3'd6;
    logic [31:0] A = '0, B = '0;
    logic        busy, stall;
    logic [31:0] HI, LO;

    int checks = 0;
    int failures = 0;
    logic [31:0] hi_m = '0, lo_m = '0;

    md_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op),
        .A(A), .B(B), .busy(busy), .stall(stall), .HI(HI), .LO(LO)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: new HI/LO from plain integer arithmetic.
    task automatic model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        longint          sp, sa, sb, q, r;
        longint unsigned up;
        case (o)
            3'd0: begin
                sa = longint'($signed(a));
                sb = longint'($signed(b));
                sp = sa * sb;
                hi_m = sp[63:32];
                lo_m = sp[31:0];
            end
            3'd1: begin
                up = longint'(a) * longint'(b);
                hi_m = up[63:32];
                lo_m = up[31:0];
            end
            3'd2: if (b != 0) begin
                sa = longint'($signed(a));
                sb = longint'($signed(b));
                q = sa / sb;
                r = sa % sb;
                lo_m = q[31:0];
                hi_m = r[31:0];
            end
            3'd3: if (b != 0) begin
                lo_m = a / b;
                hi_m = a % b;
            end
            3'd4: hi_m = a;
            3'd5: lo_m = a;
            default: ;
        endcase
    endtask

    // Issue one op at a falling edge and follow it to completion.
    // inj: fire a random extra start during the busy window.
    task automatic run_op(input logic [2:0] o, input logic [31:0] a,
                          input logic [31:0] b, input bit inj);
        int n;
        logic [31:0] h0, l0;
        n  = (o < 2) ? MC : (o < 4) ? DC : 0;
        h0 = hi_m;
        l0 = lo_m;
        @(negedge clk);
        start = 1'b1; op = o; A = a; B = b;
        #1 chk("stall_issue", {31'd0, stall}, {31'd0, o < 4});
        @(negedge clk);
        start = 1'b0; op = 3'd6;
        for (int i = 0; i < n; i++) begin
            chk("busy_run", {31'd0, busy}, 32'd1);
            chk("stall_run", {31'd0, stall}, 32'd1);
            chk("hi_hold", HI, h0);
            chk("lo_hold", LO, l0);
            if (inj && i == 1) begin
                start = 1'b1;
                op = 3'($urandom_range(0, 5));
                A = $urandom;
                B = $urandom;
            end else begin
                start = 1'b0;
                op = 3'd6;
            end
            @(negedge clk);
        end
        start = 1'b0; op = 3'd6;
        model(o, a, b);
        chk("busy_done", {31'd0, busy}, 32'd0);
        chk("stall_done", {31'd0, stall}, 32'd0);
        chk("hi_done", HI, hi_m);
        chk("lo_done", LO, lo_m);
    endtask

    initial begin
        #1;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_stall", {31'd0, stall}, 32'd0);
        chk("rst_hi", HI, 32'd0);
        chk("rst_lo", LO, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        run_op(3'd0, 32'hFFFFFFFE, 32'd3, 1'b0);
        chk("mult_hi_abs", HI, 32'hFFFFFFFF);
        chk("mult_lo_abs", LO, 32'hFFFFFFFA);
        run_op(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
        chk("multu_hi_abs", HI, 32'hFFFFFFFE);
        chk("multu_lo_abs", LO, 32'h00000001);
        run_op(3'd2, 32'hFFFFFFF9, 32'd2, 1'b0);
        chk("div_hi_abs", HI, 32'hFFFFFFFF);
        chk("div_lo_abs", LO, 32'hFFFFFFFD);
        run_op(3'd3, 32'd7, 32'd0, 1'b0);
        chk("divz_hi_abs", HI, 32'hFFFFFFFF);
        chk("divz_lo_abs", LO, 32'hFFFFFFFD);
        run_op(3'd4, 32'h12345678, 32'd0, 1'b0);
        run_op(3'd5, 32'h9ABCDEF0, 32'd0, 1'b0);
        chk("mthi_abs", HI, 32'h12345678);
        chk("mtlo_abs", LO, 32'h9ABCDEF0);
        run_op(3'd0, 32'd1000, 32'hFFFFFFF6, 1'b1);
        run_op(3'd2, 32'h80000000, 32'hFFFFFFFF, 1'b1);
        chk("ovf_hi_abs", HI, 32'h00000000);
        chk("ovf_lo_abs", LO, 32'h80000000);
        run_op(3'd7, 32'hDEADBEEF, 32'd1, 1'b0);

        // Reset in the 4th busy cycle of a divide.
        @(negedge clk);
        start = 1'b1; op = 3'd2; A = 32'd100; B = 32'd7;
        @(negedge clk);
        start = 1'b0; op = 3'd6;
        repeat (3) @(negedge clk);
        chk("pre_rst_busy", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        #1;
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_hi", HI, 32'd0);
        chk("mid_rst_lo", LO, 32'd0);
        hi_m = '0;
        lo_m = '0;
        @(negedge clk);
        reset = 1'b0;
        repeat (DC + 2) begin
            @(negedge clk);
            chk("post_rst_busy", {31'd0, busy}, 32'd0);
            chk("post_rst_hi", HI, 32'd0);
            chk("post_rst_lo", LO, 32'd0);
        end

        for (int k = 0; k < 30; k++) begin
            logic [2:0]  ro;
            logic [31:0] ra, rb;
            ro = 3'($urandom_range(0, 7));
            ra = $urandom;
            rb = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            if ($urandom_range(0, 3) == 0) rb = 32'($urandom_range(1, 20));
            run_op(ro, ra, rb, ($urandom_range(0, 2) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
